// File: rtl/mapper_ram_arbiter_if.sv
// RAM-side port of the mapper RAM arbiter. The arbiter is the master: it
// raises mem_req with address/direction/data and holds them until the RAM
// answers with a single-cycle mem_ready (read data valid in that cycle).
interface mapper_ram_arbiter_if #(
  parameter int ADDR_W = 27
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rnw;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic              mem_ready;

  modport master (
    output mem_req, mem_addr, mem_rnw, mem_din,
    input  mem_dout, mem_ready
  );

  modport slave (
    input  mem_req, mem_addr, mem_rnw, mem_din,
    output mem_dout, mem_ready
  );
endinterface

// File: rtl/mapper_ram_arbiter.sv
// Arbitrates one single-port RAM between the CPU (via the mapper chip
// select) and a loader that streams writes. The CPU normally wins a
// conflict; the loader may be granted back-to-back up to LD_MAX times while
// a CPU access waits, after which the CPU is forced through.
module mapper_ram_arbiter #(
  parameter int ADDR_W = 27,
  parameter int LD_MAX = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cpu_cs,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic                cpu_rnw,
  input  logic [7:0]          cpu_din,
  output logic [7:0]          cpu_dout,
  output logic                cpu_wait,
  input  logic                ld_req,
  input  logic [ADDR_W-1:0]   ld_addr,
  input  logic [7:0]          ld_din,
  output logic                ld_ack,
  mapper_ram_arbiter_if.master mem
);

  localparam int CNT_W = $clog2(LD_MAX + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CPU_ACC = 2'd1;
  localparam logic [1:0] LD_ACC  = 2'd2;

  logic [1:0]        state;
  logic              cs_q;
  logic              cpu_pend;
  logic              cpu_done;
  logic              cpu_abort;
  logic [ADDR_W-1:0] cpu_addr_q;
  logic              cpu_rnw_q;
  logic [7:0]        cpu_din_q;
  logic [CNT_W-1:0]  ld_cnt;

  logic              cpu_rise;
  logic              cpu_pend_now;
  logic              grant_cpu;
  logic              grant_ld;
  logic              mem_done;
  logic              cpu_complete;
  logic [ADDR_W-1:0] req_addr;
  logic              req_rnw;
  logic [7:0]        req_din;

  // Request detection, arbitration decision and CPU stall.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and no latch is inferred.
    grant_cpu = 1'b0;
    grant_ld  = 1'b0;

    // A CPU cycle starts when cs rises relative to its registered copy;
    // on that cycle the request comes straight from the inputs.
    cpu_rise     = cpu_cs & ~cs_q;
    cpu_pend_now = cpu_rise | (cpu_pend & cpu_cs);
    req_addr     = cpu_rise ? cpu_addr : cpu_addr_q;
    req_rnw      = cpu_rise ? cpu_rnw  : cpu_rnw_q;
    req_din      = cpu_rise ? cpu_din  : cpu_din_q;

    if (state == IDLE) begin
      if (cpu_pend_now &&
          (!ld_req || ld_cnt == '0 || ld_cnt == CNT_W'(LD_MAX))) begin
        grant_cpu = 1'b1;
      end else if (ld_req && !ld_ack) begin
        grant_ld = 1'b1;
      end
    end

    // mem_ready only counts while a request is actually outstanding.
    mem_done     = mem.mem_req & mem.mem_ready;
    cpu_complete = (state == CPU_ACC) && mem_done && cpu_cs && !cpu_abort;
    cpu_wait     = cpu_cs & ~cpu_done;
  end

  // FSM and RAM port: load the winning request, hold it until mem_ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      state        <= IDLE;
      mem.mem_req  <= 1'b0;
      mem.mem_rnw  <= 1'b1;
      mem.mem_addr <= '1;
      mem.mem_din  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (grant_cpu) begin
            state        <= CPU_ACC;
            mem.mem_addr <= req_addr;
            mem.mem_rnw  <= req_rnw;
            mem.mem_din  <= req_din;
          end else if (grant_ld) begin
            state        <= LD_ACC;
            mem.mem_addr <= ld_addr;
            mem.mem_rnw  <= 1'b0;
            mem.mem_din  <= ld_din;
          end
        end
        CPU_ACC, LD_ACC: begin
          if (mem_done) begin
            mem.mem_req <= 1'b0;
            state       <= IDLE;
          end else begin
            mem.mem_req <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          mem.mem_req <= 1'b0;
        end
      endcase
    end
  end

  // CPU side: capture, pending/abort tracking, completion and read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // cs_q starts high so a chip select held through reset is not
      // mistaken for a new access; it must drop and rise again.
      cs_q       <= 1'b1;
      cpu_pend   <= 1'b0;
      cpu_done   <= 1'b0;
      cpu_abort  <= 1'b0;
      cpu_addr_q <= '0;
      cpu_rnw_q  <= 1'b1;
      cpu_din_q  <= 8'h00;
      cpu_dout   <= 8'hFF;
    end else begin
      cs_q <= cpu_cs;

      if (cpu_rise) begin
        cpu_addr_q <= cpu_addr;
        cpu_rnw_q  <= cpu_rnw;
        cpu_din_q  <= cpu_din;
      end

      if (grant_cpu) begin
        cpu_pend <= 1'b0;
      end else if (cpu_rise) begin
        cpu_pend <= 1'b1;
      end else if (!cpu_cs) begin
        cpu_pend <= 1'b0;
      end

      // A cs drop while the RAM is busy orphans the access; its
      // completion must not be reported to a later CPU cycle.
      if (grant_cpu) begin
        cpu_abort <= 1'b0;
      end else if (state == CPU_ACC && !cpu_cs) begin
        cpu_abort <= 1'b1;
      end

      if (!cpu_cs) begin
        cpu_done <= 1'b0;
      end else if (cpu_complete) begin
        cpu_done <= 1'b1;
      end

      if (cpu_complete && mem.mem_rnw) begin
        cpu_dout <= mem.mem_dout;
      end
    end
  end

  // Loader side: completion pulse and the starvation counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ld_ack <= 1'b0;
      ld_cnt <= '0;
    end else begin
      ld_ack <= (state == LD_ACC) && mem_done;

      if (!cpu_pend_now || grant_cpu) begin
        ld_cnt <= '0;
      end else if (grant_ld) begin
        ld_cnt <= ld_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mapper_ram_arbiter.sv
// Directed bench for mapper_ram_arbiter with a small RAM responder whose
// latency is adjustable per scenario and a monitor logging completed
// RAM transactions in order.
module tb_mapper_ram_arbiter;

  localparam int ADDR_W = 27;
  localparam int LD_MAX = 4;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              rnw;
    logic [7:0]        din;
  } txn_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              cpu_cs = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic              cpu_rnw = 1'b1;
  logic [7:0]        cpu_din = 8'h00;
  logic [7:0]        cpu_dout;
  logic              cpu_wait;
  logic              ld_req = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [7:0]        ld_din = 8'h00;
  logic              ld_ack;

  mapper_ram_arbiter_if #(.ADDR_W(ADDR_W)) mem_bus ();

  int         tests = 0;
  int         fails = 0;
  int         ram_lat = 1;
  int         lat_cnt = 0;
  logic [7:0] rd_data = 8'h00;
  txn_t       log_q[$];
  int         stab_err = 0;
  int         ack_total = 0;
  int         ack_long = 0;
  logic       ack_prev = 1'b0;
  logic       hold_valid = 1'b0;
  txn_t       hold_t;

  mapper_ram_arbiter #(.ADDR_W(ADDR_W), .LD_MAX(LD_MAX)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cpu_cs   (cpu_cs),
    .cpu_addr (cpu_addr),
    .cpu_rnw  (cpu_rnw),
    .cpu_din  (cpu_din),
    .cpu_dout (cpu_dout),
    .cpu_wait (cpu_wait),
    .ld_req   (ld_req),
    .ld_addr  (ld_addr),
    .ld_din   (ld_din),
    .ld_ack   (ld_ack),
    .mem      (mem_bus.master)
  );

  always #5 clk = ~clk;

  assign mem_bus.mem_dout = rd_data;

  // RAM responder: ready after ram_lat falling edges of an active request.
  initial mem_bus.mem_ready = 1'b0;
  always @(negedge clk) begin
    if (mem_bus.mem_req && !mem_bus.mem_ready) begin
      if (lat_cnt >= ram_lat - 1) begin
        mem_bus.mem_ready <= 1'b1;
        lat_cnt           <= 0;
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end else begin
      mem_bus.mem_ready <= 1'b0;
      lat_cnt           <= 0;
    end
  end

  // Monitor: transaction log, request stability, ld_ack pulse shape.
  always @(posedge clk) begin
    txn_t t;
    t.addr = mem_bus.mem_addr;
    t.rnw  = mem_bus.mem_rnw;
    t.din  = mem_bus.mem_din;
    if (mem_bus.mem_req && hold_valid &&
        (t.addr !== hold_t.addr || t.rnw !== hold_t.rnw || t.din !== hold_t.din))
      stab_err <= stab_err + 1;
    hold_valid <= mem_bus.mem_req && !mem_bus.mem_ready;
    hold_t     <= t;
    if (ld_ack && ack_prev) ack_long <= ack_long + 1;
    ack_prev <= ld_ack;
    if (ld_ack) ack_total <= ack_total + 1;
    if (reset_n && mem_bus.mem_req && mem_bus.mem_ready) log_q.push_back(t);
  end

  function automatic txn_t log_at(int i);
    txn_t t;
    t.addr = 'x;
    t.rnw  = 1'bx;
    t.din  = 8'hxx;
    if (i >= 0 && i < log_q.size()) t = log_q[i];
    return t;
  endfunction

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    tick(3);
    tests++; if (mem_bus.mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req: got %b want 0", mem_bus.mem_req); end
    tests++; if (mem_bus.mem_rnw !== 1'b1) begin fails++; $display("FAIL reset_mem_rnw: got %b want 1", mem_bus.mem_rnw); end
    tests++; if (mem_bus.mem_addr !== 27'h7FFFFFF) begin fails++; $display("FAIL reset_mem_addr: got %h want 7ffffff", mem_bus.mem_addr); end
    tests++; if (mem_bus.mem_din !== 8'h00) begin fails++; $display("FAIL reset_mem_din: got %h want 00", mem_bus.mem_din); end
    tests++; if (cpu_dout !== 8'hFF) begin fails++; $display("FAIL reset_cpu_dout: got %h want ff", cpu_dout); end
    tests++; if (ld_ack !== 1'b0) begin fails++; $display("FAIL reset_ld_ack: got %b want 0", ld_ack); end
    tests++; if (cpu_wait !== 1'b0) begin fails++; $display("FAIL reset_cpu_wait: got %b want 0", cpu_wait); end
    reset_n = 1'b1;
    tick(2);
    tests++; if (mem_bus.mem_req !== 1'b0) begin fails++; $display("FAIL idle_mem_req: got %b want 0", mem_bus.mem_req); end
  endtask

  task automatic test_cpu_read;
    int k, lat;
    logic req2, rnw2;
    logic [ADDR_W-1:0] addr2;
    k = log_q.size();
    rd_data = 8'h5A; cpu_addr = 27'h0004123; cpu_rnw = 1'b1; cpu_cs = 1'b1;
    #1;
    tests++; if (cpu_wait !== 1'b1) begin fails++; $display("FAIL rd_wait_start: got %b want 1", cpu_wait); end
    lat = 0; req2 = 1'b0; rnw2 = 1'b0; addr2 = '0;
    while (cpu_wait && lat < 20) begin
      @(negedge clk); lat++;
      if (lat == 2) begin req2 = mem_bus.mem_req; rnw2 = mem_bus.mem_rnw; addr2 = mem_bus.mem_addr; end
    end
    tests++; if (lat !== 3) begin fails++; $display("FAIL rd_latency: got %0d want 3", lat); end
    tests++; if (req2 !== 1'b1) begin fails++; $display("FAIL rd_mem_req: got %b want 1", req2); end
    tests++; if (addr2 !== 27'h0004123) begin fails++; $display("FAIL rd_mem_addr: got %h want 0004123", addr2); end
    tests++; if (rnw2 !== 1'b1) begin fails++; $display("FAIL rd_mem_rnw: got %b want 1", rnw2); end
    tests++; if (cpu_dout !== 8'h5A) begin fails++; $display("FAIL rd_cpu_dout: got %h want 5a", cpu_dout); end
    tests++; if (log_q.size() !== k + 1) begin fails++; $display("FAIL rd_txn_count: got %0d want %0d", log_q.size(), k + 1); end
    cpu_cs = 1'b0;
    tick(1);
    tests++; if (cpu_wait !== 1'b0) begin fails++; $display("FAIL rd_wait_end: got %b want 0", cpu_wait); end
  endtask

  task automatic test_cpu_write;
    int k, n;
    txn_t t;
    k = log_q.size();
    rd_data = 8'hEE; cpu_addr = 27'h55; cpu_rnw = 1'b0; cpu_din = 8'h77; cpu_cs = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (cpu_wait && n < 20);
    t = log_at(k);
    tests++; if (n !== 3) begin fails++; $display("FAIL wr_latency: got %0d want 3", n); end
    tests++; if (t.addr !== 27'h55 || t.rnw !== 1'b0 || t.din !== 8'h77) begin fails++; $display("FAIL wr_txn: got %h/%b/%h want 0000055/0/77", t.addr, t.rnw, t.din); end
    tests++; if (cpu_dout !== 8'h5A) begin fails++; $display("FAIL wr_dout_hold: got %h want 5a", cpu_dout); end
    cpu_cs = 1'b0; cpu_rnw = 1'b1;
    tick(1);
  endtask

  task automatic test_loader_write;
    int k, n, acks;
    txn_t t;
    k = log_q.size();
    ld_addr = 27'h10; ld_din = 8'hC3; ld_req = 1'b1;
    n = 0; acks = 0;
    while (acks == 0 && n < 20) begin
      @(negedge clk); n++;
      if (ld_ack) begin acks++; ld_req = 1'b0; end
    end
    t = log_at(k);
    tests++; if (n !== 3) begin fails++; $display("FAIL ld_latency: got %0d want 3", n); end
    tests++; if (t.addr !== 27'h10 || t.rnw !== 1'b0 || t.din !== 8'hC3) begin fails++; $display("FAIL ld_txn: got %h/%b/%h want 0000010/0/c3", t.addr, t.rnw, t.din); end
    tick(1);
    tests++; if (ld_ack !== 1'b0) begin fails++; $display("FAIL ld_ack_pulse: got %b want 0", ld_ack); end
    tests++; if (log_q.size() !== k + 1) begin fails++; $display("FAIL ld_txn_count: got %0d want %0d", log_q.size(), k + 1); end
  endtask

  task automatic test_simultaneous;
    int k, n;
    logic ld_done, cpu_fin;
    txn_t t0, t1;
    k = log_q.size();
    rd_data = 8'h66; cpu_addr = 27'h200; cpu_rnw = 1'b1;
    ld_addr = 27'h300; ld_din = 8'h99;
    cpu_cs = 1'b1; ld_req = 1'b1;
    n = 0; ld_done = 1'b0; cpu_fin = 1'b0;
    while (!(ld_done && cpu_fin) && n < 40) begin
      @(negedge clk); n++;
      if (ld_ack) begin ld_req = 1'b0; ld_done = 1'b1; end
      if (!cpu_wait) cpu_fin = 1'b1;
    end
    t0 = log_at(k); t1 = log_at(k + 1);
    tests++; if (!(ld_done && cpu_fin)) begin fails++; $display("FAIL sim_done: got ld=%b cpu=%b want 1/1", ld_done, cpu_fin); end
    tests++; if (t0.addr !== 27'h200 || t0.rnw !== 1'b1) begin fails++; $display("FAIL sim_first: got %h/%b want 0000200/1", t0.addr, t0.rnw); end
    tests++; if (t1.addr !== 27'h300 || t1.rnw !== 1'b0 || t1.din !== 8'h99) begin fails++; $display("FAIL sim_second: got %h/%b/%h want 0000300/0/99", t1.addr, t1.rnw, t1.din); end
    tests++; if (cpu_dout !== 8'h66) begin fails++; $display("FAIL sim_dout: got %h want 66", cpu_dout); end
    cpu_cs = 1'b0;
    tick(1);
  endtask

  task automatic test_ld_streaming;
    int k0, cpu_k, j, ld_idx, ld_n, between;
    logic cpu_fin, last_seen;
    k0 = log_q.size();
    ld_idx = 0; ld_addr = 27'h1000; ld_din = 8'h40; ld_req = 1'b1;
    rd_data = 8'h2B; cpu_k = 0; cpu_fin = 1'b0;
    for (int cyc = 0; cyc < 200 && !(ld_idx == 8 && cpu_fin); cyc++) begin
      @(negedge clk);
      if (cyc > 0 && cpu_cs && !cpu_wait) cpu_fin = 1'b1;
      if (ld_ack) begin
        ld_idx++;
        if (ld_idx < 8) begin ld_addr = 27'h1000 + ADDR_W'(ld_idx); ld_din = 8'h40 + 8'(ld_idx); end
        else ld_req = 1'b0;
      end
      if (cyc == 0) begin cpu_k = log_q.size(); cpu_addr = 27'h0ABC; cpu_rnw = 1'b1; cpu_cs = 1'b1; end
    end
    j = -1; ld_n = 0; last_seen = 1'b0;
    for (int i = k0; i < log_q.size(); i++) begin
      if (log_q[i].rnw === 1'b1 && j < 0 && i >= cpu_k) j = i;
      if (log_q[i].rnw === 1'b0) ld_n++;
      if (log_q[i].addr === 27'h1007 && log_q[i].din === 8'h47) last_seen = 1'b1;
    end
    between = j - cpu_k - 1;
    tests++; if (!cpu_fin || j < 0) begin fails++; $display("FAIL stream_cpu_served: got fin=%b idx=%0d want served", cpu_fin, j); end
    tests++; if (between < 0 || between > LD_MAX) begin fails++; $display("FAIL stream_ld_grants: got %0d want 0..%0d", between, LD_MAX); end
    tests++; if (ld_n !== 8 || ld_idx !== 8) begin fails++; $display("FAIL stream_ld_count: got %0d txns %0d acks want 8", ld_n, ld_idx); end
    tests++; if (!last_seen) begin fails++; $display("FAIL stream_last_write: got missing want 0001007/47"); end
    tests++; if (cpu_dout !== 8'h2B) begin fails++; $display("FAIL stream_dout: got %h want 2b", cpu_dout); end
    cpu_cs = 1'b0;
    tick(1);
  endtask

  task automatic test_cpu_abort;
    int k, n;
    txn_t t;
    k = log_q.size();
    ram_lat = 4; rd_data = 8'h11; cpu_addr = 27'h777; cpu_rnw = 1'b1; cpu_cs = 1'b1;
    tick(2);
    tests++; if (mem_bus.mem_req !== 1'b1) begin fails++; $display("FAIL abort_req_up: got %b want 1", mem_bus.mem_req); end
    cpu_cs = 1'b0;
    n = 0;
    while (log_q.size() == k && n < 20) begin @(negedge clk); n++; end
    tick(1);
    t = log_at(k);
    tests++; if (t.addr !== 27'h777 || t.rnw !== 1'b1) begin fails++; $display("FAIL abort_txn_done: got %h/%b want 0000777/1", t.addr, t.rnw); end
    tests++; if (mem_bus.mem_req !== 1'b0) begin fails++; $display("FAIL abort_req_down: got %b want 0", mem_bus.mem_req); end
    tests++; if (cpu_dout !== 8'h2B) begin fails++; $display("FAIL abort_dout: got %h want 2b", cpu_dout); end
    tests++; if (cpu_wait !== 1'b0) begin fails++; $display("FAIL abort_wait: got %b want 0", cpu_wait); end
    ram_lat = 1;
  endtask

  task automatic test_reset_mid;
    int k, n, ack0, bad;
    txn_t t;
    k = log_q.size(); ack0 = ack_total;
    ram_lat = 4; ld_addr = 27'h20; ld_din = 8'h5D; ld_req = 1'b1;
    n = 0;
    while (mem_bus.mem_req !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    tests++; if (mem_bus.mem_req !== 1'b1) begin fails++; $display("FAIL rst_req_up: got %b want 1", mem_bus.mem_req); end
    cpu_addr = 27'h999; cpu_rnw = 1'b1; cpu_cs = 1'b1; reset_n = 1'b0;
    #1;
    tests++; if (mem_bus.mem_req !== 1'b0 || mem_bus.mem_rnw !== 1'b1) begin fails++; $display("FAIL rst_mid_req: got req=%b rnw=%b want 0/1", mem_bus.mem_req, mem_bus.mem_rnw); end
    tests++; if (mem_bus.mem_addr !== 27'h7FFFFFF || mem_bus.mem_din !== 8'h00) begin fails++; $display("FAIL rst_mid_bus: got %h/%h want 7ffffff/00", mem_bus.mem_addr, mem_bus.mem_din); end
    tests++; if (cpu_dout !== 8'hFF || ld_ack !== 1'b0) begin fails++; $display("FAIL rst_mid_out: got dout=%h ack=%b want ff/0", cpu_dout, ld_ack); end
    tick(2);
    reset_n = 1'b1;
    n = 0;
    while (ld_req && n < 30) begin
      @(negedge clk); n++;
      if (ld_ack) ld_req = 1'b0;
    end
    tick(4);
    t = log_at(k);
    bad = 0;
    for (int i = k; i < log_q.size(); i++) if (log_q[i].addr === 27'h999) bad++;
    tests++; if (ack_total - ack0 !== 1) begin fails++; $display("FAIL rst_ack_count: got %0d want 1", ack_total - ack0); end
    tests++; if (log_q.size() !== k + 1 || t.addr !== 27'h20 || t.din !== 8'h5D) begin fails++; $display("FAIL rst_reserve: got n=%0d %h/%h want 1 0000020/5d", log_q.size() - k, t.addr, t.din); end
    tests++; if (bad !== 0 || cpu_wait !== 1'b1) begin fails++; $display("FAIL rst_held_cs: got served=%0d wait=%b want 0/1", bad, cpu_wait); end
    cpu_cs = 1'b0;
    tick(1);
    ram_lat = 1; rd_data = 8'h3C; cpu_cs = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (cpu_wait && n < 20);
    t = log_at(log_q.size() - 1);
    tests++; if (cpu_dout !== 8'h3C || t.addr !== 27'h999) begin fails++; $display("FAIL rst_cs_reraise: got %h/%h want 3c/0000999", cpu_dout, t.addr); end
    cpu_cs = 1'b0;
    tick(1);
  endtask

  task automatic test_bus_integrity;
    tests++; if (stab_err !== 0) begin fails++; $display("FAIL bus_stable: got %0d changes want 0", stab_err); end
    tests++; if (ack_long !== 0) begin fails++; $display("FAIL ack_width: got %0d long pulses want 0", ack_long); end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_loader_write();
    test_simultaneous();
    test_ld_streaming();
    test_cpu_abort();
    test_reset_mid();
    test_bus_integrity();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mapper_ram_arbiter.md
MAPPER_RAM_ARBITER -- requirements
Module: mapper_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 27, meaning the RAM address width, matching mapper output addr.
REQ-002 SHALL have parameter LD_MAX, default 4, meaning the maximum back-to-back loader grants while a CPU request waits.
REQ-003 clk  in  1  system clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 cpu_cs  in  1  mapper RAM chip select (out.ram_cs); level, held for the whole CPU cycle.
REQ-006 cpu_addr  in  ADDR_W  mapper address; valid while cpu_cs=1.
REQ-007 cpu_rnw  in  1  1=read, 0=write.
REQ-008 cpu_din  in  8  CPU write data.
REQ-009 cpu_dout  out  8  read data returned to the CPU.
REQ-010 cpu_wait  out  1  stalls the CPU until its access completes.
REQ-011 ld_req  in  1  loader write request; held until ld_ack.
REQ-012 ld_addr  in  ADDR_W  loader write address.
REQ-013 ld_din  in  8  loader write data.
REQ-014 ld_ack  out  1  single-cycle completion pulse for a loader write.
REQ-015 mem_req  out  1  RAM port request; held until mem_ready.
REQ-016 mem_addr  out  ADDR_W  RAM port address.
REQ-017 mem_rnw  out  1  RAM port direction.
REQ-018 mem_din  out  8  RAM port write data.
REQ-019 mem_dout  in  8  RAM port read data; valid in the mem_ready cycle.
REQ-020 mem_ready  in  1  single-cycle RAM completion pulse.

Function
REQ-021 SHALL detect a new CPU access on a 0->1 transition of registered cpu_cs; the address, direction and data are captured in that same cycle.
REQ-022 SHALL drive cpu_wait = cpu_cs AND NOT cpu_done (combinational); cpu_done sets on completion of the CPU transaction and clears when cpu_cs=0.
REQ-023 SHALL implement FSM states IDLE, CPU_ACC, LD_ACC.
REQ-024 IDLE: if CPU pending and (no ld_req OR ld_cnt==LD_MAX) -> CPU_ACC; else if ld_req and no ld_ack in the previous cycle -> LD_ACC; else stay in IDLE.
REQ-025 When CPU pending and ld_req are simultaneous and ld_cnt<LD_MAX, SHALL grant the loader and increment ld_cnt; ld_cnt clears on every CPU grant and whenever no CPU request is pending.
REQ-026 When both are pending, SHALL grant the CPU first if ld_cnt==0 (CPU priority on first conflict); in all other cases REQ-024 applies.
REQ-027 On entry to CPU_ACC/LD_ACC, SHALL assert mem_req on the next clk edge with mem_addr/mem_rnw/mem_din from the captured request (loader: mem_rnw=0).
REQ-028 SHALL keep mem_req, mem_addr, mem_rnw and mem_din stable until mem_ready; on mem_ready, mem_req drops on the following clk edge.
REQ-029 On mem_ready in CPU_ACC: latch mem_dout into cpu_dout on reads, set cpu_done, and return to IDLE.
REQ-030 On mem_ready in LD_ACC: pulse ld_ack for one cycle and return to IDLE.
REQ-031 mem_ready received in IDLE SHALL be ignored.
REQ-032 If cpu_cs falls during CPU_ACC, SHALL complete the RAM transaction, discard the completion, and leave cpu_done=0.
REQ-033 Minimum latency SHALL be 3 cycles from request detection to completion with mem_ready returned 1 cycle after mem_req: grant, mem_req, ready.
REQ-034 cpu_dout SHALL hold its last read value between CPU reads.

Reset
REQ-035 While reset_n=0, SHALL force: FSM=IDLE, mem_req=0, mem_rnw=1, mem_addr=all ones, mem_din=0, cpu_dout=FF, cpu_done=0, ld_ack=0, ld_cnt=0.
REQ-036 Reset asserted mid-transaction SHALL abort immediately without ld_ack; after release, a still-asserted ld_req is re-served and a held cpu_cs is only served after it goes 0 and back to 1.

Verification
REQ-037 CPU read cpu_addr=0x0004123, mem_dout=0x5A, mem_ready 1 cycle after mem_req -> mem_req with mem_addr=0x0004123 and mem_rnw=1; cpu_wait=1 until cpu_dout=0x5A.
REQ-038 Loader write ld_addr=0x10, ld_din=0xC3 -> mem_req with mem_rnw=0 and mem_din=0xC3; one ld_ack pulse after mem_ready.
REQ-039 Loader streaming continuously with a CPU read pending, LD_MAX=4 -> the loader is granted at most 4 consecutive times, then the CPU is granted and ld_cnt=0.
REQ-040 CPU and loader requests in the same cycle with ld_cnt=0 -> CPU served first, loader next.
REQ-041 cpu_cs dropped during CPU_ACC -> transaction completes; no cpu_dout update; cpu_wait=0.
REQ-042 reset_n pulsed low while mem_req=1 -> all outputs at reset values at once; ld_ack never pulses for the aborted write.
